control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
// - Parametrised microcoded successor to the fixed fetch-only control unit: drives the CPU control_bus from a T-step counter and a microcode ROM.
// - Microcode address = {opcode, step}. Step 0 is a hard-wired FETCH.
// - Adds variable-length instructions, memory wait-states, conditional early termination, single-step mode, halt handling and a sequencing-error flag.
// - Sits between IR0/ALU status and the CPU datapath decoders (MID/SID/AMID); replaces the free-running timer + timer_decoder.
// PARAMETERS
// - OPC_W     3   opcode width taken from ir0[OPC_W-1:0]
// - STEP_W    3   step counter width; MAX_STEPS = 2**STEP_W
// - CB_W      33  control_bus width (field map in cpu_pkg)
// - MEM_ID    4   MID/SID value addressing memory (wait-state qualifier)
// PORTS
// - clk          in   1         system clock, rising edge
// - reset        in   1         asynchronous, active-low reset
// - hlt          in   1         external halt request, sampled at instruction boundary
// - run_mode     in   1         1 = free run, 0 = single-step
// - step         in   1         single-step advance pulse (one instruction per pulse)
// - mem_ready    in   1         memory ready; 0 stretches a memory step
// - ir0          in   8         instruction register 0 contents
// - alu_status   in   4         {V,N,Z,C} from ALU/status register
// - control_bus  out  CB_W      ALU_OPCODE,MID,SID,AMID,MID_EN,SID_EN,PC_INR,HLT,CLR_TIMER
// - T            out  MAX_STEPS one-hot current step
// - instr_done   out  1         1-cycle pulse on last step of each instruction
// - halted       out  1         1 while in S_HALT or S_PAUSE
// - seq_err      out  1         sticky: instruction ran MAX_STEPS steps without end bit
// BEHAVIOUR
// - Reset (reset=0): state S_FETCH, step 0, seq_err 0.
//   - While asserted: control_bus all-zero, T=0, instr_done 0, halted 0.
// - States: S_FETCH, S_EXEC, S_PAUSE, S_HALT.
// - S_FETCH (step 0): bus = AMID 0 (PC), MID MEM_ID, SID 0 (IR0), MID_EN=SID_EN=PC_INR=1; T=1.
//   - Advances to S_EXEC step 1 when mem_ready=1.
// - S_EXEC: bus = ucode_rom[{ir0[OPC_W-1:0], step}]. Microword end bit (CLR_TIMER) ends the instruction:
//   - instr_done=1 that cycle.
//   - Next state: S_PAUSE if run_mode=0; S_HALT if HLT bit set or hlt=1; else S_FETCH.
// - Conditional end: microword COND_EN with COND_SEL picks an alu_status bit.
//   - Bit == COND_POL: step treated as end step; its SID_EN/PC_INR still take effect.
// - Wait-state: step with MID==MEM_ID or SID==MEM_ID and mem_ready=0 holds step/state.
//   - SID_EN and PC_INR forced 0 during the hold, so nothing commits twice.
//   - The transfer commits on the ready cycle.
// - Overflow: step==MAX_STEPS-1 with no end bit -> treated as end; seq_err set (sticky until reset).
// - S_PAUSE: bus zero, halted=1; step=1 -> S_FETCH next cycle. run_mode=1 also exits.
// - S_HALT: bus zero except HLT bit=1, halted=1.
//   - Entered via hlt: exits to S_FETCH the cycle after hlt=0.
//   - Entered via HLT microbit: exits only by reset.
// - hlt asserted mid-instruction: instruction completes; no effect until boundary.
// - Step counter wraps only via end/overflow, never silently. No combinational path from inputs to state except mem_ready/alu_status gating.
// STRUCTURE
// - cpu_pkg: CB_* field ranges, microword field ranges (COND_EN, COND_SEL, COND_POL), MID/SID/AMID ID constants, state enum.
// - Sub-module ucode_rom: combinational, addr {OPC_W+STEP_W}, returns microword; table in one case statement.
//   - ADDB = {ALU_OPCODE=op, MID=18 ALU, SID=2 A, both EN, CLR_TIMER}.
// - control_sequencer holds FSM, step counter, gating, one-hot T decode.
// TESTING
// - Reset: hold reset=0 3 cycles -> control_bus=0, T=0. Release -> first cycle T=8'h01, MID=4, SID=0, PC_INR=1.
// - ADDB (ir0=8'h02), mem_ready=1: fetch T=01, exec T=02 with MID=18, SID=2.
//   - instr_done pulse at T=02; next cycle T=01.
// - Wait: mem_ready=0 for 3 cycles in fetch -> T=01 held 4 cycles, PC_INR=0, SID_EN=0 for 3 of them, single PC increment.
// - Cond end: COND_SEL=Z, alu_status=4'b0010 -> instruction ends at step 1, step 2 never asserted.
// - Halt/step: hlt=1 mid-instruction -> halted only after instr_done; hlt=0 -> fetch next cycle.
//   - run_mode=0 -> one instruction per step pulse.
// - Overflow: ROM entry with no end bit -> 8 steps then fetch; seq_err=1 until reset.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the control sequencer.
// - Control bus field positions (CB_*).
// - Microword condition fields, which sit just above the control bus bits (UW_*).
// - Datapath source/destination IDs used on MID/SID/AMID.
// - Sequencer state enum, plus a helper that packs a control word.
package cpu_pkg;
  localparam int OPC_W_DEF  = 3;
  localparam int STEP_W_DEF = 3;
  localparam int CB_W_DEF   = 33;
  localparam int MEM_ID_DEF = 4;

  // Control bus field map. Bits [CB_W-1:CB_FW] are spare and always zero.
  localparam int CB_CLR_TIMER = 0;
  localparam int CB_HLT       = 1;
  localparam int CB_PC_INR    = 2;
  localparam int CB_SID_EN    = 3;
  localparam int CB_MID_EN    = 4;
  localparam int CB_AMID_LO   = 5;
  localparam int CB_AMID_HI   = 8;
  localparam int CB_SID_LO    = 9;
  localparam int CB_SID_HI    = 13;
  localparam int CB_MID_LO    = 14;
  localparam int CB_MID_HI    = 18;
  localparam int CB_ALU_LO    = 19;
  localparam int CB_ALU_HI    = 26;
  localparam int CB_FW        = 27;

  // Condition fields, as offsets above the control bus inside a microword.
  localparam int UW_COND_POL    = 0;
  localparam int UW_COND_SEL_LO = 1;
  localparam int UW_COND_SEL_HI = 2;
  localparam int UW_COND_EN     = 3;

  // COND_SEL indexes alu_status = {V,N,Z,C}.
  localparam logic [1:0] SEL_C = 2'd0;
  localparam logic [1:0] SEL_Z = 2'd1;
  localparam logic [1:0] SEL_N = 2'd2;
  localparam logic [1:0] SEL_V = 2'd3;

  // Datapath IDs.
  localparam logic [4:0] ID_IR0 = 5'd0;
  localparam logic [4:0] ID_IR1 = 5'd1;
  localparam logic [4:0] ID_A   = 5'd2;
  localparam logic [4:0] ID_B   = 5'd3;
  localparam logic [4:0] ID_MEM = 5'(MEM_ID_DEF);
  localparam logic [4:0] ID_OUT = 5'd5;
  localparam logic [4:0] ID_ALU = 5'd18;
  localparam logic [3:0] AM_PC  = 4'd0;
  localparam logic [3:0] AM_IR1 = 4'd1;

  localparam logic [7:0] ALU_NOP = 8'h00;
  localparam logic [7:0] ALU_ADD = 8'h01;
  localparam logic [7:0] ALU_SUB = 8'h02;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_PAUSE, S_HALT} state_t;

  // Pack the populated control bus fields, LSB = CLR_TIMER.
  function automatic logic [CB_FW-1:0] cw(
    input logic [7:0] alu, input logic [4:0] mid, input logic [4:0] sid,
    input logic [3:0] amid, input logic mid_en, input logic sid_en,
    input logic pc_inr, input logic hlt, input logic clr);
    return {alu, mid, sid, amid, mid_en, sid_en, pc_inr, hlt, clr};
  endfunction
endpackage

// File: rtl/ucode_rom.sv
// Microcode ROM: combinational lookup of the microword at addr = {opcode, step}.
// - addr  : {opcode, step}
// - uword : {cond_en, cond_sel[1:0], cond_pol, control_bus[CB_W-1:0]}
// Step 0 is never looked up because FETCH is hard-wired in the sequencer.
// Opcode 5 is deliberately left unprogrammed and has no end bit. It exercises
// the overflow path.
module ucode_rom
  import cpu_pkg::*;
#(
  parameter int OPC_W  = OPC_W_DEF,
  parameter int STEP_W = STEP_W_DEF,
  parameter int CB_W   = CB_W_DEF,
  parameter int MEM_ID = MEM_ID_DEF
) (
  input  logic [OPC_W+STEP_W-1:0] addr,
  output logic [CB_W+3:0]         uword
);
  localparam logic [4:0] MEM = 5'(MEM_ID);

  logic [CB_FW-1:0] core;
  logic [3:0]       cond;  // {en, sel[1:0], pol}

  function automatic logic [OPC_W+STEP_W-1:0] ua(input int op, input int st);
    return (OPC_W+STEP_W)'((op << STEP_W) | st);
  endfunction

  always_comb begin
    core = '0;
    cond = '0;
    case (addr)
      // NOP
      ua(0, 1): core = cw(ALU_NOP, 5'd0, 5'd0, AM_PC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      // LDA: memory -> A, stretched by mem_ready
      ua(1, 1): core = cw(ALU_NOP, MEM, ID_A, AM_IR1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      // ADDB: ALU -> A
      ua(2, 1): core = cw(ALU_ADD, ID_ALU, ID_A, AM_PC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      // A -> B, finishing early when Z=1. Otherwise SUB -> A.
      ua(3, 1): begin
        core = cw(ALU_NOP, ID_A, ID_B, AM_PC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cond = {1'b1, SEL_Z, 1'b1};
      end
      ua(3, 2): core = cw(ALU_SUB, ID_ALU, ID_A, AM_PC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      // Three-step: A -> B, ADD -> A, A -> OUT
      ua(4, 1): core = cw(ALU_NOP, ID_A, ID_B, AM_PC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      ua(4, 2): core = cw(ALU_ADD, ID_ALU, ID_A, AM_PC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      ua(4, 3): core = cw(ALU_NOP, ID_A, ID_OUT, AM_PC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      // HLT
      ua(6, 1): core = cw(ALU_NOP, 5'd0, 5'd0, AM_PC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      // Two-byte instruction: operand fetch into IR1 with PC increment, then IR1 -> A
      ua(7, 1): core = cw(ALU_NOP, MEM, ID_IR1, AM_PC, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      ua(7, 2): core = cw(ALU_NOP, ID_IR1, ID_A, AM_PC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      default: ;
    endcase
    uword = {cond, (CB_W-CB_FW)'(0), core};
  end
endmodule

// File: rtl/control_sequencer.sv
// Microcoded CPU control sequencer.
// - Inputs: clk, reset (async, active low), hlt, run_mode, step, mem_ready,
//   ir0, alu_status {V,N,Z,C}.
// - Outputs:
//   - control_bus: datapath control word.
//   - T: one-hot step.
//   - instr_done: pulse on the last step of an instruction.
//   - halted: high in pause or halt.
//   - seq_err: sticky, set by step-counter overflow.
// Step 0 is a hard-wired fetch. Later steps come from ucode_rom.
// Outputs decode from the registered state and step. Only mem_ready and
// alu_status gate them combinationally, through stalls and conditional ends.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int OPC_W  = OPC_W_DEF,
  parameter int STEP_W = STEP_W_DEF,
  parameter int CB_W   = CB_W_DEF,
  parameter int MEM_ID = MEM_ID_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hlt,
  input  logic                 run_mode,
  input  logic                 step,
  input  logic                 mem_ready,
  input  logic [7:0]           ir0,
  input  logic [3:0]           alu_status,
  output logic [CB_W-1:0]      control_bus,
  output logic [2**STEP_W-1:0] T,
  output logic                 instr_done,
  output logic                 halted,
  output logic                 seq_err
);
  localparam logic [4:0] MEM = 5'(MEM_ID);

  state_t            state;
  logic [STEP_W-1:0] step_cnt;
  logic              halt_lock;  // halt came from the HLT microbit, so only reset leaves it
  logic [CB_W+3:0]   uword;
  logic [CB_W-1:0]   ubus;
  logic              mem_step, stall, end_bit, cond_hit, ovf, exec_last;
  logic              unused_ir0;

  ucode_rom #(.OPC_W(OPC_W), .STEP_W(STEP_W), .CB_W(CB_W), .MEM_ID(MEM_ID)) u_rom (
    .addr  ({ir0[OPC_W-1:0], step_cnt}),
    .uword (uword)
  );

  assign unused_ir0 = ^ir0[7:OPC_W];
  assign ubus       = uword[CB_W-1:0];
  assign end_bit    = ubus[CB_CLR_TIMER];
  assign mem_step   = (ubus[CB_MID_HI:CB_MID_LO] == MEM) || (ubus[CB_SID_HI:CB_SID_LO] == MEM);
  assign stall      = mem_step && !mem_ready;
  assign cond_hit   = uword[CB_W+UW_COND_EN] &&
                      (alu_status[uword[CB_W+UW_COND_SEL_HI:CB_W+UW_COND_SEL_LO]] == uword[CB_W+UW_COND_POL]);
  // The last step has no end of its own. It is forced to end and flagged.
  assign ovf        = (step_cnt == '1) && !end_bit && !cond_hit;
  assign exec_last  = !stall && (end_bit || cond_hit || ovf);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_FETCH;
      step_cnt  <= '0;
      seq_err   <= 1'b0;
      halt_lock <= 1'b0;
    end else begin
      case (state)
        S_FETCH: if (mem_ready) begin
          state    <= S_EXEC;
          step_cnt <= STEP_W'(1);
        end
        S_EXEC: if (!stall) begin
          if (exec_last) begin
            step_cnt <= '0;
            if (ovf) seq_err <= 1'b1;
            if (!run_mode) state <= S_PAUSE;
            else if (ubus[CB_HLT] || hlt) begin
              state     <= S_HALT;
              halt_lock <= ubus[CB_HLT];
            end else state <= S_FETCH;
          end else step_cnt <= step_cnt + 1'b1;
        end
        S_PAUSE: if (step || run_mode) state <= S_FETCH;
        S_HALT:  if (!halt_lock && !hlt) state <= S_FETCH;
        default: state <= S_FETCH;
      endcase
    end
  end

  // While reset is low, every output is blanked, although the state already reads FETCH.
  always_comb begin
    control_bus = '0;
    T           = '0;
    instr_done  = 1'b0;
    halted      = 1'b0;
    if (reset) begin
      case (state)
        S_FETCH: begin
          control_bus[CB_MID_HI:CB_MID_LO]   = MEM;
          control_bus[CB_SID_HI:CB_SID_LO]   = ID_IR0;
          control_bus[CB_AMID_HI:CB_AMID_LO] = AM_PC;
          control_bus[CB_MID_EN]             = 1'b1;
          // Commit only on the ready cycle, so IR0 loads once and PC steps once.
          control_bus[CB_SID_EN]             = mem_ready;
          control_bus[CB_PC_INR]             = mem_ready;
          T[0]                               = 1'b1;
        end
        S_EXEC: begin
          control_bus = ubus;
          if (stall) begin
            control_bus[CB_SID_EN] = 1'b0;
            control_bus[CB_PC_INR] = 1'b0;
          end
          T[step_cnt] = 1'b1;
          instr_done  = exec_last;
        end
        S_PAUSE: halted = 1'b1;
        S_HALT: begin
          control_bus[CB_HLT] = 1'b1;
          halted              = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;
  import cpu_pkg::*;

  logic            clk = 1'b0;
  logic            reset, hlt, run_mode, step, mem_ready;
  logic [7:0]      ir0;
  logic [3:0]      alu_status;
  logic [CB_W_DEF-1:0] control_bus;
  logic [7:0]      T;
  logic            instr_done, halted, seq_err;
  int              errors = 0;
  int              checks = 0;

  control_sequencer dut (
    .clk(clk), .reset(reset), .hlt(hlt), .run_mode(run_mode), .step(step),
    .mem_ready(mem_ready), .ir0(ir0), .alu_status(alu_status),
    .control_bus(control_bus), .T(T), .instr_done(instr_done),
    .halted(halted), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [4:0] f_mid(input logic [CB_W_DEF-1:0] b);
    return b[CB_MID_HI:CB_MID_LO];
  endfunction
  function automatic logic [4:0] f_sid(input logic [CB_W_DEF-1:0] b);
    return b[CB_SID_HI:CB_SID_LO];
  endfunction

  // Reference model: the architectural view of each opcode.
  // Number of exec steps (the step that carries instr_done).
  function automatic int exec_len(input int op, input logic [3:0] a);
    case (op)
      3:       return a[1] ? 1 : 2;  // ends early when Z=1
      4:       return 3;
      7:       return 2;
      default: return 1;
    endcase
  endfunction
  // The step touches memory and is therefore stretched by mem_ready.
  function automatic logic is_mem(input int op, input int s);
    return (s == 0) || (s == 1 && (op == 1 || op == 7));
  endfunction
  // The step increments the PC once it commits.
  function automatic logic pc_inc(input int op, input int s);
    return (s == 0) || (op == 7 && s == 1);
  endfunction

  task automatic apply_reset;
    reset = 1'b0; hlt = 1'b0; run_mode = 1'b1; step = 1'b0;
    mem_ready = 1'b1; ir0 = 8'h00; alu_status = 4'h0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0; hlt = 1'b0; run_mode = 1'b1; step = 1'b0;
    mem_ready = 1'b1; ir0 = 8'h02; alu_status = 4'h0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1; checks++;
      if (control_bus !== '0 || T !== 8'h00 || instr_done !== 1'b0 || halted !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: bus=%h T=%h done=%b halted=%b, want all zero",
                 control_bus, T, instr_done, halted);
      end
      @(negedge clk);
    end
    reset = 1'b1; #1; checks++;
    if (T !== 8'h01 || f_mid(control_bus) !== 5'd4 || f_sid(control_bus) !== 5'd0 ||
        control_bus[CB_PC_INR] !== 1'b1 || seq_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: T=%h mid=%0d sid=%0d pc=%b err=%b, want T=01 mid=4 sid=0 pc=1 err=0",
               T, f_mid(control_bus), f_sid(control_bus), control_bus[CB_PC_INR], seq_err);
    end
    @(negedge clk);
  endtask

  task automatic test_addb;
    apply_reset; ir0 = 8'h02; #1; checks++;
    if (T !== 8'h01 || instr_done !== 1'b0) begin
      errors++; $display("FAIL addb_fetch: T=%h done=%b, want 01/0", T, instr_done);
    end
    @(negedge clk); #1; checks++;
    if (T !== 8'h02 || f_mid(control_bus) !== 5'd18 || f_sid(control_bus) !== 5'd2 ||
        control_bus[CB_ALU_HI:CB_ALU_LO] !== ALU_ADD || instr_done !== 1'b1) begin
      errors++;
      $display("FAIL addb_exec: T=%h mid=%0d sid=%0d done=%b, want 02 18 2 1",
               T, f_mid(control_bus), f_sid(control_bus), instr_done);
    end
    @(negedge clk); #1; checks++;
    if (T !== 8'h01) begin errors++; $display("FAIL addb_next: T=%h want 01", T); end
    @(negedge clk);
  endtask

  task automatic test_wait;
    int pcs = 0;
    apply_reset; ir0 = 8'h00; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      #1; checks++;
      pcs += int'(control_bus[CB_PC_INR]);
      if (T !== 8'h01 || (i < 3 && (control_bus[CB_PC_INR] !== 1'b0 || control_bus[CB_SID_EN] !== 1'b0))) begin
        errors++;
        $display("FAIL wait_cycle%0d: T=%h pc=%b sid_en=%b, want T=01 and no commit while waiting",
                 i, T, control_bus[CB_PC_INR], control_bus[CB_SID_EN]);
      end
      @(negedge clk);
    end
    #1; checks++;
    if (pcs != 1 || T !== 8'h02) begin
      errors++; $display("FAIL wait_commit: pc pulses=%0d T=%h, want 1 and 02", pcs, T);
    end
    @(negedge clk);
  endtask

  task automatic test_cond;
    apply_reset; ir0 = 8'h03; alu_status = 4'b0010;
    @(negedge clk); #1; checks++;
    if (T !== 8'h02 || instr_done !== 1'b1 || control_bus[CB_SID_EN] !== 1'b1) begin
      errors++; $display("FAIL cond_taken: T=%h done=%b sid_en=%b, want 02 1 1", T, instr_done, control_bus[CB_SID_EN]);
    end
    @(negedge clk); #1; checks++;
    if (T !== 8'h01) begin errors++; $display("FAIL cond_skip: T=%h want 01", T); end
    alu_status = 4'b0000;
    @(negedge clk); #1; checks++;
    if (T !== 8'h02 || instr_done !== 1'b0) begin
      errors++; $display("FAIL cond_not_taken: T=%h done=%b, want 02 0", T, instr_done);
    end
    @(negedge clk); #1; checks++;
    if (T !== 8'h04 || instr_done !== 1'b1) begin
      errors++; $display("FAIL cond_step2: T=%h done=%b, want 04 1", T, instr_done);
    end
    @(negedge clk);
  endtask

  task automatic test_halt_step;
    apply_reset; ir0 = 8'h04;
    @(negedge clk);
    hlt = 1'b1;  // step 1 of a three-step instruction
    for (int s = 1; s <= 3; s++) begin
      #1; checks++;
      if (halted !== 1'b0 || instr_done !== 1'(s == 3) || T !== 8'(1 << s)) begin
        errors++; $display("FAIL hlt_mid s=%0d: halted=%b done=%b T=%h", s, halted, instr_done, T);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 2) hlt = 1'b0;
      #1; checks++;
      if (halted !== 1'b1 || control_bus !== (CB_W_DEF'(1) << CB_HLT)) begin
        errors++; $display("FAIL hlt_hold%0d: halted=%b bus=%h, want 1 and HLT only", i, halted, control_bus);
      end
      @(negedge clk);
    end
    #1; checks++;
    if (halted !== 1'b0 || T !== 8'h01) begin
      errors++; $display("FAIL hlt_exit: halted=%b T=%h, want 0 01", halted, T);
    end
    // The HLT microbit stops the sequencer until reset.
    ir0 = 8'h06;
    @(negedge clk); #1; checks++;
    if (instr_done !== 1'b1) begin errors++; $display("FAIL hltbit_done: done=%b want 1", instr_done); end
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1; checks++;
      if (halted !== 1'b1 || control_bus[CB_HLT] !== 1'b1) begin
        errors++; $display("FAIL hltbit_stuck%0d: halted=%b hlt_bit=%b, want 1 1", i, halted, control_bus[CB_HLT]);
      end
      @(negedge clk);
    end
    // Single-step mode: one instruction per step pulse.
    apply_reset; run_mode = 1'b0; ir0 = 8'h02;
    for (int n = 0; n < 2; n++) begin
      #1; checks++;
      if (T !== 8'h01 || halted !== 1'b0) begin
        errors++; $display("FAIL ss_fetch%0d: T=%h halted=%b, want 01 0", n, T, halted);
      end
      @(negedge clk); #1; checks++;
      if (instr_done !== 1'b1) begin errors++; $display("FAIL ss_done%0d: done=%b want 1", n, instr_done); end
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (i == 2) step = 1'b1;
        #1; checks++;
        if (halted !== 1'b1 || control_bus !== '0) begin
          errors++; $display("FAIL ss_pause%0d_%0d: halted=%b bus=%h, want 1 0", n, i, halted, control_bus);
        end
        @(negedge clk);
        step = 1'b0;
      end
    end
  endtask

  task automatic test_overflow;
    apply_reset; ir0 = 8'h05;
    @(negedge clk);
    for (int s = 1; s < 8; s++) begin
      #1; checks++;
      if (T !== 8'(1 << s) || instr_done !== 1'(s == 7) || seq_err !== 1'b0) begin
        errors++; $display("FAIL ovf_step%0d: T=%h done=%b err=%b", s, T, instr_done, seq_err);
      end
      @(negedge clk);
    end
    ir0 = 8'h02; #1; checks++;
    if (T !== 8'h01 || seq_err !== 1'b1) begin
      errors++; $display("FAIL ovf_end: T=%h err=%b, want 01 1", T, seq_err);
    end
    repeat (2) @(negedge clk);
    #1; checks++;
    if (seq_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: err=%b want 1", seq_err); end
    reset = 1'b0; #1; checks++;
    if (seq_err !== 1'b0) begin errors++; $display("FAIL ovf_clear: err=%b want 0", seq_err); end
    @(negedge clk);
  endtask

  task automatic test_random;
    int ops [6] = '{0, 1, 2, 3, 4, 7};
    int op, n, k;
    logic [3:0] a;
    apply_reset;
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 5)];
      a  = 4'($urandom);
      ir0 = 8'(op); alu_status = a;
      n = exec_len(op, a);
      for (int s = 0; s <= n; s++) begin
        if (is_mem(op, s)) begin
          k = $urandom_range(0, 2);
          for (int w = 0; w < k; w++) begin
            mem_ready = 1'b0; #1; checks++;
            if (T !== 8'(1 << s) || control_bus[CB_PC_INR] !== 1'b0 ||
                control_bus[CB_SID_EN] !== 1'b0 || instr_done !== 1'b0) begin
              errors++;
              $display("FAIL rand_stall op=%0d s=%0d: T=%h pc=%b sid_en=%b done=%b, want T=%h 0 0 0",
                       op, s, T, control_bus[CB_PC_INR], control_bus[CB_SID_EN], instr_done, 8'(1 << s));
            end
            @(negedge clk);
          end
          mem_ready = 1'b1;
        end else mem_ready = 1'($urandom);
        #1; checks++;
        if (T !== 8'(1 << s) || instr_done !== 1'(s == n) || control_bus[CB_PC_INR] !== pc_inc(op, s)) begin
          errors++;
          $display("FAIL rand_step op=%0d s=%0d: T=%h done=%b pc=%b, want T=%h done=%b pc=%b",
                   op, s, T, instr_done, control_bus[CB_PC_INR], 8'(1 << s), s == n, pc_inc(op, s));
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_addb;
    test_wait;
    test_cond;
    test_halt_step;
    test_overflow;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
